// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// The ST_* state encodings are common to every serial block in this family,
// so that debug tooling can decode any of them the same way.
package twos_to_signmag_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default word width for the serial converters.
    localparam int SM_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/twos_to_signmag_serial_negate_cell.sv
// Per-bit copy/invert cell for serial two's-complement negation.
// Bits are copied up to and including the first 1 seen since clr, and every
// bit after that is inverted.
// When neg is low, bits pass straight through.
module serial_negate_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic neg,
    input  logic b_in,
    output logic r_out
);

    logic seen_one;

    // Remember whether a 1 has already passed through the current word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | b_in;
        end
    end

    // Invert only after the first 1, and only for negative words.
    always_comb begin
        r_out = b_in;
        if (neg && seen_one) begin
            r_out = ~b_in;
        end
    end

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// The word is processed LSB first, one bit per clock, with valid/ready
// handshakes on both the input and output sides.
// Optional macro SM_SATURATE_EN: the most negative input reports all-ones
// (-(2^(WIDTH-1)-1)) instead of the raw {1, zeros} pattern. ovf is set either way.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a word; in_ready high
// ST_CONV | shifting WIDTH bits through the negate cell, one per clock
// ST_DONE | result presented on out_data/ovf until out_ready
module twos_to_signmag_serial
    import twos_to_signmag_serial_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] res;
    logic             sign;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             step;
    logic             r_bit;
    logic             res_zero;
    logic             ovf_w;
    logic [WIDTH-1:0] data_raw;
    logic [WIDTH-1:0] data_sel;

    // in_ready is held low while reset is asserted so no word can be taken then.
    assign in_ready = (state == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign step     = (state == ST_CONV);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)          state_nx = ST_CONV;
            ST_CONV: if (cnt == CNT_LAST) state_nx = ST_DONE;
            ST_DONE: if (out_ready)       state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    // Load a word on accept, then shift one bit per clock while converting.
    // Result bits enter at the MSB, so after WIDTH steps res is in normal bit order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            res   <= '0;
            sign  <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= in_data;
            res   <= '0;
            sign  <= in_data[WIDTH-1];
            cnt   <= '0;
        end else if (step) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            res   <= {r_bit, res[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    serial_negate_cell u_neg (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (step),
        .neg   (sign),
        .b_in  (shreg[0]),
        .r_out (r_bit)
    );

    // Format the result. A negated non-zero word is never zero, so res_zero
    // only matters for a zero input; it keeps the sign bit clear there. The
    // most negative input negates to itself, which leaves res[WIDTH-1] set.
    always_comb begin
        res_zero = ~|res;
        ovf_w    = sign & res[WIDTH-1];
        data_raw = {sign & ~res_zero, res[WIDTH-2:0]};
`ifdef SM_SATURATE_EN
        data_sel = ovf_w ? '1 : data_raw;
`else
        data_sel = data_raw;
`endif
    end

    // Outputs are held at zero outside DONE.
    always_comb begin
        out_valid = (state == ST_DONE);
        busy      = (state == ST_CONV) || (state == ST_DONE);
        out_data  = out_valid ? data_sel : '0;
        ovf       = out_valid & ovf_w;
    end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
module tb_twos_to_signmag_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    twos_to_signmag_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: signed value in, {ovf, sign-magnitude} out, by plain arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] x);
        int v;
        int mag;
        v = int'($signed(x));
        if (v >= 0) return {1'b0, W'(v)};
        if (v == -(1 << (W - 1))) begin
`ifdef SM_SATURATE_EN
            return {1'b1, {W{1'b1}}};
`else
            return {1'b1, 1'b1, {(W-1){1'b0}}};
`endif
        end
        mag = -v;
        return {1'b0, 1'b1, (W-1)'(mag)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one word and wait for the result. lat = cycles from accept to out_valid,
    // -1 if the block never became ready, 99 if no result appeared.
    task automatic convert(input logic [W-1:0] d, output logic [W-1:0] got,
                           output logic got_ovf, output int lat, output int acc_cyc);
        int k;
        k = 0;
        lat = -1;
        got = '0;
        got_ovf = 1'b0;
        acc_cyc = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) return;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!out_valid && lat < 99) begin
            tick();
            lat++;
        end
        got     = out_data;
        got_ovf = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_data !== '0 || ovf !== 1'b0)
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h ovf=%b, required 0 0 0 00 0",
                     in_ready, out_valid, busy, out_data, ovf);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [W-1:0] vec[8] = '{8'h05, 8'hFB, 8'hFF, 8'h9C, 8'h00, 8'h7F, 8'h80, 8'h01};
        logic [W-1:0] got;
        logic g_ovf;
        logic [W:0] exp;
        int lat, ac;
        out_ready = 1'b1;
        foreach (vec[i]) begin
            convert(vec[i], got, g_ovf, lat, ac);
            exp = model(vec[i]);
            n_checks++;
            if (lat !== W) $display("FAIL vec_latency in=%h: got %0d required %0d", vec[i], lat, W);
            else n_pass++;
            n_checks++;
            if (got !== exp[W-1:0] || g_ovf !== exp[W])
                $display("FAIL vec_result in=%h: got %h ovf %b required %h ovf %b",
                         vec[i], got, g_ovf, exp[W-1:0], exp[W]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        logic g_ovf;
        logic [W:0] exp;
        int lat, ac, ac_prev;
        logic [W-1:0] d;
        out_ready = 1'b1;
        ac_prev = -1;
        for (int i = 0; i < 6; i++) begin
            d = W'($urandom);
            convert(d, got, g_ovf, lat, ac);
            exp = model(d);
            n_checks++;
            if (got !== exp[W-1:0] || g_ovf !== exp[W] || lat !== W)
                $display("FAIL b2b_result in=%h: got %h ovf %b lat %0d required %h ovf %b lat %0d",
                         d, got, g_ovf, lat, exp[W-1:0], exp[W], W);
            else n_pass++;
            if (ac_prev >= 0) begin
                n_checks++;
                if (ac - ac_prev !== W + 2)
                    $display("FAIL b2b_period: got %0d required %0d", ac - ac_prev, W + 2);
                else n_pass++;
            end
            ac_prev = ac;
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL b2b_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got;
        logic g_ovf;
        int lat, ac;
        int bad;
        out_ready = 1'b0;
        convert(8'h9C, got, g_ovf, lat, ac);
        n_checks++;
        if (got !== 8'hE4 || g_ovf !== 1'b0 || lat !== W)
            $display("FAIL bp_result: got %h ovf %b lat %0d required e4 0 %0d", got, g_ovf, lat, W);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_data  = 8'h05;
            tick();
            if (out_valid !== 1'b1 || out_data !== 8'hE4 || ovf !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL bp_ignored_pulse: busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_midconv();
        logic [W-1:0] got;
        logic g_ovf;
        int lat, ac;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h80;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL midrst_ready_in_rst: got %b required 0", in_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midrst_state: out_valid=%b busy=%b in_ready=%b required 0 0 1",
                     out_valid, busy, in_ready);
        else n_pass++;
        convert(8'h9C, got, g_ovf, lat, ac);
        n_checks++;
        if (got !== 8'hE4 || g_ovf !== 1'b0 || lat !== W)
            $display("FAIL midrst_next: got %h ovf %b lat %0d required e4 0 %0d", got, g_ovf, lat, W);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] got;
        logic g_ovf;
        logic [W:0] exp;
        int lat, ac;
        logic [W-1:0] d;
        for (int i = 0; i < 40; i++) begin
            d = W'($urandom);
            out_ready = $urandom_range(0, 1);
            convert(d, got, g_ovf, lat, ac);
            exp = model(d);
            n_checks++;
            if (got !== exp[W-1:0] || g_ovf !== exp[W] || lat !== W)
                $display("FAIL rand_result in=%h: got %h ovf %b lat %0d required %h ovf %b lat %0d",
                         d, got, g_ovf, lat, exp[W-1:0], exp[W], W);
            else n_pass++;
            for (int k = 0; k < $urandom_range(0, 3); k++) tick();
            out_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_midconv();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
